// File: rtl/alu_pkg.sv
// Shared types and constants for the lab ALU op sequencer: op codes, one-hot flags, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_XOR = 4'd6,
    OP_OR  = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_NOP = 4'hF
  } alu_op_e;

  localparam logic [3:0] FLAG_CARRY = 4'b0001;
  localparam logic [3:0] FLAG_ZERO  = 4'b0010;
  localparam logic [3:0] FLAG_NEG   = 4'b0100;
  localparam logic [3:0] FLAG_OVF   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus between the op sequencer (master) and the combinational ALU core (slave).
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int N = 4
) ();

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  alu_op_e      alu_op;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_flags
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_flags
  );

endinterface

// File: rtl/btn_press_detect.sv
// Two-flop synchronizer plus falling-edge detect for active-low push buttons; press is registered.
module btn_press_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_n,
  output logic [W-1:0] press
);

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] prev_q,  prev_d;
  logic [W-1:0] press_q, press_d;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = ~sync2_q & prev_q;
  end

  // Synchronizer and history reset to all-ones so a button held through reset reads as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      press_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the value from before the edge.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Turns button presses into single ALU transactions: latch operands/op, settle, capture result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        a_sw,
  input  logic [N-1:0]        b_sw,
  input  logic [3:0]          btn_n,
  input  logic [1:0]          mode_sw,
  alu_op_sequencer_if.master  alu,
  output logic [N-1:0]        result_q,
  output logic [3:0]          flags_q,
  output logic [3:0]          op_q,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [3:0]    press;
  logic [1:0]    idx;
  logic [3:0]    code;
  logic          req_ok;

  state_e        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [N-1:0]  alu_a_q,  alu_a_d;
  logic [N-1:0]  alu_b_q,  alu_b_d;
  alu_op_e       alu_op_q, alu_op_d;
  logic [N-1:0]  result_d;
  logic [3:0]    flags_d;
  logic [3:0]    op_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          err_q,    err_d;

  btn_press_detect #(.W(4)) u_press (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .press (press)
  );

  // idx is only meaningful when exactly one press is present; req_ok guards that.
  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) idx = 2'(i);
    end
    code   = {mode_sw, idx};
    req_ok = ($countones(press) == 1) && is_legal_op(code);
  end

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    flags_d  = flags_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|press) begin
          if (req_ok) begin
            alu_a_d  = a_sw;
            alu_b_d  = b_sw;
            alu_op_d = alu_op_e'(code);
            cnt_d    = CW'(SETTLE - 1);
            busy_d   = 1'b1;
            state_d  = ST_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // Capture happens on the edge leaving EXEC so done lands exactly SETTLE cycles after issue.
        if (cnt_q == '0) begin
          result_d = alu.alu_result;
          flags_d  = alu.alu_flags;
          op_d     = alu_op_q;
          alu_op_d = OP_NOP;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_CAPT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_NOP;
      result_q <= '0;
      flags_q  <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign alu.alu_a  = alu_a_q;
  assign alu.alu_b  = alu_b_q;
  assign alu.alu_op = alu_op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
